// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
// Constants track the default datapath width.
package multdiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int ITER_LAST = WIDTH_DEF - 1;
    localparam logic [WIDTH_DEF-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// trial-subtract/restore for divide. Purely combinational.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               mode_div,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] opa_i,
    input  logic [WIDTH:0]     opb_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] opa_o,
    output logic [WIDTH:0]     opb_o
);

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;
    logic             q_bit;

    always_comb begin
        // Divide: acc holds the partial remainder, opa the dividend that
        // turns into the quotient as bits are shifted in from the right.
        rem_shift = {acc_i[WIDTH-1:0], opa_i[WIDTH-1]};
        trial     = {1'b0, rem_shift} - {1'b0, opb_i};
        q_bit     = ~trial[WIDTH+1];

        acc_o = acc_i;
        opa_o = opa_i;
        opb_o = opb_i;

        if (mode_div) begin
            acc_o = {{(WIDTH-1){1'b0}}, (q_bit ? trial[WIDTH:0] : rem_shift)};
            opa_o = {{WIDTH{1'b0}}, opa_i[WIDTH-2:0], q_bit};
        end else begin
            // Multiply: multiplicand walks left, multiplier walks right.
            if (opb_i[0]) begin
                acc_o = acc_i + opa_i;
            end
            opa_o = {opa_i[2*WIDTH-2:0], 1'b0};
            opb_o = {1'b0, opb_i[WIDTH:1]};
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: WIDTH iterations per operation,
// registered outputs and a one-cycle result-ready pulse.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_LAST);

    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] neg_v;
        neg_v = {WIDTH{1'b0}} - v;
        return v[WIDTH-1] ? {1'b0, neg_v} : {1'b0, v};
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH:0]     opb_q, opb_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic [2*WIDTH-1:0] step_acc, step_opa;
    logic [WIDTH:0]     step_opb;
    logic               start;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   q_mag, q_s;
    logic               mult_exc, div_exc;

    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_div (state_q == DIV),
        .acc_i    (acc_q),
        .opa_i    (opa_q),
        .opb_i    (opb_q),
        .acc_o    (step_acc),
        .opa_o    (step_opa),
        .opb_o    (step_opb)
    );

    // Both pulses high at once is not a valid request and is ignored.
    assign start = ctrl_MULT ^ ctrl_DIV;

    // Sign fix-up on the values the final iteration produces.
    always_comb begin
        prod_s   = neg_q ? ({(2*WIDTH){1'b0}} - step_acc) : step_acc;
        mult_exc = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
        q_mag    = step_opa[WIDTH-1:0];
        q_s      = neg_q ? ({WIDTH{1'b0}} - q_mag) : q_mag;
        // Only INT_MIN / -1 yields a positive quotient of 2^(WIDTH-1).
        div_exc  = !neg_q && (q_mag == INT_MIN);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (start) begin
            state_d  = ctrl_MULT ? MULT : DIV;
            cnt_d    = '0;
            acc_d    = '0;
            opa_d    = {{(WIDTH-1){1'b0}}, magnitude(data_operandA)};
            opb_d    = magnitude(data_operandB);
            neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            result_d = '0;
            exc_d    = 1'b0;
        end else begin
            case (state_q)
                MULT, DIV: begin
                    if (state_q == DIV && opb_q == '0) begin
                        state_d  = DONE;
                        result_d = '0;
                        exc_d    = 1'b1;
                        rdy_d    = 1'b1;
                    end else begin
                        acc_d = step_acc;
                        opa_d = step_opa;
                        opb_d = step_opb;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_d  = DONE;
                            rdy_d    = 1'b1;
                            result_d = (state_q == MULT) ? prod_s[WIDTH-1:0] : q_s;
                            exc_d    = (state_q == MULT) ? mult_exc : div_exc;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed vectors push expected results,
// a negedge monitor pops and checks value, exception and arrival cycle.
module tb_multdiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    multdiv_unit dut (
        .clock          (clk),
        .reset          (rst),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int unsigned due;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every RDY pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rdy: actual=rdy at cycle %0d result=%h required=no rdy",
                         cyc, data_result);
            end else begin
                mon_e = sb.pop_front();
                $display("txn %s: result=%h exc=%b cycle=%0d", mon_e.name, data_result,
                         data_exception, cyc);
                check({mon_e.name, "_result"}, 64'(data_result), 64'(mon_e.res));
                check({mon_e.name, "_exc"}, 64'(data_exception), 64'(mon_e.exc));
                check({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    task automatic issue(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_rdy, input logic [31:0] r, input logic x,
                         input int lat, input string name);
        @(negedge clk);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = !is_div;
        ctrl_DIV = is_div;
        if (expect_rdy)
            sb.push_back('{res: r, exc: x, due: cyc + 1 + lat, name: name});
        @(negedge clk);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        // Scramble operands: the unit must have latched them at the start edge.
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: actual=%0d pending required=0 pending", name, sb.size());
            sb.delete();
        end
    endtask

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        x;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{0, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 32, "mul_7_m6"};
        vecs[1] = '{0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 32, "mul_ovf"};
        vecs[2] = '{0, 32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, 32, "mul_intmin"};
        vecs[3] = '{1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 32, "div_m7_2"};
        vecs[4] = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32, "div_ovf"};
        vecs[5] = '{1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1, 1,  "div_by_0"};
        vecs[6] = '{1, 32'h0000_00C8, 32'hFFFF_FFF9, 32'hFFFF_FFE4, 1'b0, 32, "div_200_m7"};

        repeat (3) @(negedge clk);
        check("reset_result", 64'(data_result), 64'h0);
        check("reset_exc", 64'(data_exception), 64'h0);
        check("reset_rdy", 64'(data_resultRDY), 64'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].is_div, vecs[i].a, vecs[i].b, 1'b1, vecs[i].r, vecs[i].x,
                  vecs[i].lat, vecs[i].name);
            wait_drain(vecs[i].name);
            repeat (3) @(negedge clk);
            check({vecs[i].name, "_hold_result"}, 64'(data_result), 64'(vecs[i].r));
            check({vecs[i].name, "_hold_exc"}, 64'(data_exception), 64'(vecs[i].x));
            check({vecs[i].name, "_hold_rdy"}, 64'(data_resultRDY), 64'h0);
        end

        // Both start pulses together: ignored, previous result held.
        @(negedge clk);
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        ctrl_MULT = 1'b1;
        ctrl_DIV = 1'b1;
        @(negedge clk);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        repeat (40) @(negedge clk);
        check("both_high_result", 64'(data_result), 64'hFFFF_FFE4);
        check("both_high_rdy", 64'(data_resultRDY), 64'h0);

        // Abort: multiply restarted by a divide at cycle 10.
        issue(0, 32'd3, 32'd4, 1'b0, 32'h0, 1'b0, 32, "abort_mul");
        repeat (8) @(negedge clk);
        issue(1, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, 32, "abort_div");
        check("abort_start_clears", 64'(data_result), 64'h0);
        wait_drain("abort_div");
        repeat (40) @(negedge clk);

        // Asynchronous reset with a held nonzero result.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_result", 64'(data_result), 64'h0);
        check("async_rst_exc", 64'(data_exception), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-multiply: the in-flight operation never reports.
        issue(0, 32'd5, 32'd5, 1'b0, 32'h0, 1'b0, 32, "rst_mul");
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midop_rst_result", 64'(data_result), 64'h0);
        check("midop_rst_rdy", 64'(data_resultRDY), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        issue(0, 32'd2, 32'd3, 1'b1, 32'd6, 1'b0, 32, "mul_2_3");
        wait_drain("mul_2_3");
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=time limit reached required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit sitting directly downstream of the register file.
- Consumes the two register read ports as operands; its result is returned through the writeback path to the register file's write port.
- Multi-cycle. The control stalls the pipeline from a start pulse until the ready pulse.
- Multiply is radix-2 shift-add on magnitudes with sign fix-up. Divide is restoring division on magnitudes with sign fix-up.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- data_operandA  input  WIDTH  multiplicand/dividend (register file read port A).
- data_operandB  input  WIDTH  multiplier/divisor (register file read port B).
- ctrl_MULT  input  1  one-cycle start pulse for a multiply.
- ctrl_DIV  input  1  one-cycle start pulse for a divide.
- data_result  output  WIDTH  low WIDTH bits of the product, or the quotient.
- data_exception  output  1  overflow or divide-by-zero flag; valid with data_resultRDY.
- data_resultRDY  output  1  result-valid pulse, exactly one cycle wide.

Behaviour:
- Reset: asynchronous and active-high, taking effect immediately, including mid-operation.
  - State goes to IDLE; counter, operand registers and accumulators go to 0.
  - data_result=0, data_exception=0, data_resultRDY=0.
  - Any operation in flight is dropped; no RDY is ever produced for it.
- States: IDLE, MULT, DIV, DONE (binary-encoded).
- Start: sampled at rising edge E0 with exactly one of ctrl_MULT/ctrl_DIV high.
  - At E0, operands and operand signs are latched and the counter is cleared.
  - State goes to MULT or DIV.
  - Operands are not sampled again after E0.
- Both ctrl_MULT and ctrl_DIV high in the same cycle: ignored. No state change, outputs held.
- Start while in MULT, DIV or DONE: aborts the current operation and restarts with the new operands. The aborted operation produces no RDY.
- Iteration: one iteration per edge, E1..E32.
  - The counter increments each iteration.
  - At E32 (counter reaches WIDTH-1 before the edge) the sign fix-up is applied, data_result and data_exception are registered, and state goes to DONE.
- DONE: data_resultRDY=1 for exactly the one cycle between E32 and E33; state returns to IDLE at E33.
  - Latency is therefore 32 cycles from the start edge to the RDY-visible cycle.
- data_result and data_exception hold their values after RDY until the next start or reset. At a start edge both are cleared to 0.
- Multiply:
  - Full 2*WIDTH signed product formed internally.
  - data_result = low WIDTH bits.
  - data_exception=1 iff the product is not representable as a WIDTH-bit signed value (upper WIDTH+1 bits not all equal).
- Divide:
  - Signed, quotient truncated toward zero; the remainder is discarded.
  - Divisor 0 is a short path: state goes to DONE at E1, RDY is visible in the cycle after E1, data_result=0, data_exception=1.
  - 0x80000000 / 0xFFFFFFFF: full 32 iterations, data_result=0x80000000, data_exception=1.
- Width rules:
  - Magnitudes are held in WIDTH+1 bits so |0x80000000| is handled.
  - The division partial remainder is WIDTH+1 bits; the product accumulator is 2*WIDTH bits.
- The block produces no combinational paths from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package (multdiv_pkg):
  - State encoding constants: IDLE, MULT, DIV, DONE.
  - WIDTH default and ITER_LAST = WIDTH-1.
  - Constant INT_MIN = 0x80000000.
- One sub-module, multdiv_step: the combinational single-iteration datapath.
  - Add/shift for multiply.
  - Trial-subtract/restore for divide, selected by mode.
  - Instantiated once in multdiv_unit, which owns the FSM, counter and registers.

Test Plan:
- 7 * -6 (0x00000007, 0xFFFFFFFA), ctrl_MULT pulse -> data_result=0xFFFFFFD6, data_exception=0. RDY high exactly one cycle, first seen 32 cycles after the start edge.
- 0x00010000 * 0x00010000 -> data_result=0x00000000, data_exception=1. Also -65536*32768 -> 0x80000000, exception=0.
- -7 / 2 (0xFFFFFFF9, 0x00000002), ctrl_DIV -> data_result=0xFFFFFFFD, exception=0. Also 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception=1.
- 5 / 0 -> RDY in the cycle after the start edge, data_result=0, data_exception=1. Then the unit returns to IDLE and accepts a new start.
- Start MULT 3*4; at cycle 10 pulse ctrl_DIV with 100/7 -> no RDY for the multiply. A single RDY 32 cycles after the DIV edge with data_result=14.
- Start MULT; assert reset asynchronously at cycle 10 (mid-clock) -> outputs go to 0 immediately and no RDY appears within 40 cycles. After reset release, 2*3 -> 6.
